cargador_programa: RTL and testbench
====================================

Name: cargador_programa

Overview:
- Writer side of the program memory port: serial bytes from the UART receiver are packed into instruction words and written sequentially into program memory.
- Before loading, it clears the memory through the memory's active-low soft reset.
- It stops on a HALT word or when memory is full, then reports completion to the debug unit.
- It sits between the UART RX / debug unit and the program memory (i_addr, dina, wea, ena, soft_reset).

Parameters:
- RAM_WIDTH, 32, instruction word width; must be a multiple of 8.
- RAM_DEPTH, 2048, number of memory words.
- ADDR_WIDTH, 11, address width; must equal clog2(RAM_DEPTH).
- HALT_WORD, 32'hFFFFFFFF, word that ends a load; it is written to memory before finishing.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low.
- i_start  in  1  one-cycle pulse that requests a new load.
- i_rx_data  in  8  byte from the UART receiver.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- o_soft_reset  out  1  to memory soft_reset, active-low; low means clear.
- o_addr  out  ADDR_WIDTH  memory write address.
- o_dina  out  RAM_WIDTH  memory write data.
- o_wea  out  1  memory write enable, one-cycle pulse.
- o_ena  out  1  memory enable; equals o_wea.
- o_busy  out  1  high in CLEAR and RECV.
- o_done  out  1  high in DONE.
- o_overflow  out  1  load ended because memory filled without a HALT word.
- o_word_count  out  ADDR_WIDTH+1  number of words written in the current load.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_soft_reset=1.
  - o_addr, o_dina, o_wea, o_ena, o_busy, o_done, o_overflow, o_word_count = 0.
  - Internal byte index = 0, clear counter = 0.
  - State = IDLE.
- State IDLE: on i_start go to CLEAR. On entry, o_word_count, o_overflow and o_addr are set to 0. i_rx_valid is ignored in IDLE.
- State CLEAR:
  - o_soft_reset=0 for exactly RAM_DEPTH cycles, counted by a clear counter of width ADDR_WIDTH+1.
  - After that, o_soft_reset=1 and the state goes to RECV.
  - Bytes arriving during CLEAR are dropped.
  - i_start is ignored.
- State RECV, byte packing:
  - Each i_rx_valid byte is shifted into the assembly register MSB-first. The first byte lands in bits [RAM_WIDTH-1 : RAM_WIDTH-8].
  - The byte index counts 0 .. RAM_WIDTH/8-1.
- State RECV, word write:
  - The cycle after the last byte of a word is accepted: o_dina = assembled word, o_wea = o_ena = 1 for exactly one cycle, o_addr = current address.
  - In the cycle after the write: o_addr increments and o_word_count increments.
- State RECV, overlapping byte: a byte arriving in the write cycle is accepted as byte 0 of the next word. No byte is lost.
- State RECV, termination:
  - If the written word equals HALT_WORD, go to DONE after the write cycle, with o_overflow=0.
  - Else, if the word was written to address RAM_DEPTH-1, go to DONE with o_overflow=1. o_addr does not wrap and holds RAM_DEPTH-1.
  - HALT_WORD at the last address gives o_overflow=0.
- State RECV: i_start is ignored; a partially received word persists indefinitely (no timeout).
- State DONE:
  - o_done=1.
  - o_addr, o_word_count and o_overflow hold.
  - Bytes are ignored.
  - i_start goes to CLEAR, which restarts the load and resets the counters as on IDLE entry.
- Async reset mid-CLEAR or mid-RECV aborts immediately to reset values. Memory contents may be partially cleared or written; o_soft_reset returns high.
- Outside RECV, o_wea never asserts. o_wea and o_soft_reset=0 are never active in the same cycle.

Test Plan:
- Reset, then idle 20 cycles -> o_soft_reset=1, o_wea=0, o_busy=0, o_done=0, o_word_count=0.
- RAM_DEPTH=16, ADDR_WIDTH=4, i_start pulse -> o_soft_reset low for exactly 16 cycles, then RECV; a byte strobed during CLEAR is not captured.
- Bytes 12 34 56 78, then AA BB CC DD, then FF FF FF FF:
  - writes 0x12345678@0, 0xAABBCCDD@1, 0xFFFFFFFF@2, each a single-cycle o_wea.
  - Ends with o_done=1, o_word_count=3, o_overflow=0.
- Back-to-back strobes: byte 0 of word 1 arrives in word 0's write cycle -> word 1 assembles correctly.
- RAM_DEPTH=16, send 16 non-HALT words -> 16 writes at addresses 0..15, o_overflow=1, o_word_count=16, o_addr=15; further bytes cause no writes.
- Async reset after 2 bytes of a word, then new i_start -> full CLEAR; the next word written at address 0 contains only new bytes. A second i_start from DONE also restarts at address 0.

Source files
------------

// File: rtl/cargador_programa.sv
// cargador_programa
//   Loads a program into memory from a UART byte stream. On i_start the memory
//   is cleared through its active-low soft reset (RAM_DEPTH cycles). The block
//   then packs incoming bytes MSB-first into RAM_WIDTH words and writes them to
//   consecutive addresses. Loading stops on HALT_WORD, which is itself written,
//   or after the last address has been written (overflow).
//
// Ports
//   i_clk, i_reset      clock (rising edge), asynchronous active-low reset
//   i_start             one-cycle load request (honoured in IDLE and DONE)
//   i_rx_data/valid     byte stream from the UART receiver
//   o_soft_reset        memory clear, active-low
//   o_addr/o_dina       memory write address / data
//   o_wea/o_ena         memory write enable (single-cycle pulse); o_ena == o_wea
//   o_busy/o_done       status: clearing or receiving / load finished
//   o_overflow          load ended on a full memory without HALT_WORD
//   o_word_count        words written in the current load
module cargador_programa #(
  parameter int                   RAM_WIDTH  = 32,
  parameter int                   RAM_DEPTH  = 2048,
  parameter int                   ADDR_WIDTH = 11,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_soft_reset,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [RAM_WIDTH-1:0]  o_dina,
  output logic                  o_wea,
  output logic                  o_ena,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int NB = RAM_WIDTH / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0]         BYTE_LAST = BW'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CLR_LAST  = (ADDR_WIDTH + 1)'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RECV, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [RAM_WIDTH-1:0]  asm_q, asm_d, asm_shifted;
  logic                  soft_q, soft_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]  dina_q, dina_d;
  logic                  wea_q, wea_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH:0]   wc_q, wc_d;
  logic                  term;

  assign asm_shifted = (asm_q << 8) | RAM_WIDTH'(i_rx_data);

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    soft_d     = soft_q;
    addr_d     = addr_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    ovf_d      = ovf_q;
    wc_d       = wc_q;
    term       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d    = S_CLEAR;
          clr_cnt_d  = '0;
          byte_idx_d = '0;
          soft_d     = 1'b0;
          addr_d     = '0;
          wc_d       = '0;
          ovf_d      = 1'b0;
        end
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          soft_d    = 1'b1;
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        // Bookkeeping for the write happening this cycle; a byte arriving in
        // the same cycle still feeds the next word unless the load ends here.
        if (wea_q) begin
          wc_d = wc_q + 1'b1;
          if (dina_q == HALT_WORD) begin
            state_d = S_DONE;
            ovf_d   = 1'b0;
            term    = 1'b1;
          end else if (addr_q == ADDR_LAST) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
            term    = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        if (i_rx_valid && !term) begin
          asm_d = asm_shifted;
          if (byte_idx_q == BYTE_LAST) begin
            byte_idx_d = '0;
            dina_d     = asm_shifted;
            wea_d      = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR) || (state_d == S_RECV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      soft_q     <= 1'b1;
      addr_q     <= '0;
      dina_q     <= '0;
      wea_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      soft_q     <= soft_d;
      addr_q     <= addr_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wc_q       <= wc_d;
    end
  end

  assign o_soft_reset = soft_q;
  assign o_addr       = addr_q;
  assign o_dina       = dina_q;
  assign o_wea        = wea_q;
  assign o_ena        = wea_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = wc_q;

endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa with a 16-word, 32-bit memory.
module tb_cargador_programa;

  localparam int DEPTH = 16;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        o_soft_reset;
  logic [3:0]  o_addr;
  logic [31:0] o_dina;
  logic        o_wea, o_ena, o_busy, o_done, o_overflow;
  logic [4:0]  o_word_count;

  cargador_programa #(
    .RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(4), .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_soft_reset(o_soft_reset), .o_addr(o_addr), .o_dina(o_dina),
    .o_wea(o_wea), .o_ena(o_ena), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow), .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write log and per-cycle protocol invariants.
  logic [3:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic        prev_wea = 1'b0;
  always @(negedge i_clk) begin
    if (o_wea) begin
      wr_a.push_back(o_addr);
      wr_d.push_back(o_dina);
    end
    chk("wea_protocol",
        {63'd0, (o_ena === o_wea) && !(o_wea && (!o_soft_reset || !o_busy || prev_wea))},
        64'd1);
    prev_wea = o_wea;
  end

  // Reference model: words sent after CLEAR -> expected writes.
  logic [31:0] tx_words[$];
  logic [3:0]  exp_a[$];
  logic [31:0] exp_d[$];
  bit          exp_ovf;

  task automatic model();
    exp_a.delete(); exp_d.delete();
    foreach (tx_words[i]) begin
      exp_a.push_back(4'(i));
      exp_d.push_back(tx_words[i]);
      if (tx_words[i] == HALT || exp_d.size() == DEPTH) break;
    end
    exp_ovf = (exp_d[$] != HALT);
  endtask

  task automatic pulse_start();
    @(negedge i_clk) i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  // Called at a negedge; holds the byte for one cycle then idles gap cycles.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    i_rx_valid = 1'b1; i_rx_data = b;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
  endtask

  // Start a load, verify CLEAR length (with a byte injected during it), send
  // tx_words, and wait for DONE.
  task automatic run_load(input int unsigned gap_max);
    int unsigned low = 0;
    wr_a.delete(); wr_d.delete();
    pulse_start();
    for (int c = 0; c < 100; c++) begin
      @(negedge i_clk);
      i_rx_valid = (c == 3); i_rx_data = 8'h99;
      if (!o_soft_reset) low++;
      if (o_soft_reset && o_busy) break;
    end
    i_rx_valid = 1'b0;
    chk("recv_entry", {63'd0, o_soft_reset && o_busy}, 64'd1);
    chk("clear_len", 64'(low), 64'(DEPTH));
    foreach (tx_words[i])
      for (int b = 0; b < 4; b++)
        send_byte(tx_words[i][31-8*b -: 8], $urandom_range(0, gap_max));
    for (int c = 0; c < 200 && !o_done; c++) @(negedge i_clk);
    chk("done_reached", {63'd0, o_done}, 64'd1);
    repeat (2) @(negedge i_clk);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_nwrites"}, 64'(wr_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < wr_d.size() && i < exp_d.size(); i++) begin
      chk({tag, "_addr"}, 64'(wr_a[i]), 64'(exp_a[i]));
      chk({tag, "_data"}, 64'(wr_d[i]), 64'(exp_d[i]));
    end
    chk({tag, "_count"}, 64'(o_word_count), 64'(exp_d.size()));
    chk({tag, "_ovf"}, 64'(o_overflow), 64'(exp_ovf));
    chk({tag, "_addr_hold"}, 64'(o_addr), 64'(exp_a[$]));
    chk({tag, "_status"}, {62'd0, o_busy, o_done}, 64'd1);
  endtask

  typedef struct {
    int unsigned n;
    logic [31:0] w[4];
    int unsigned cnt;
    bit          ovf;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{n: 3, w: '{32'h12345678, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h0}, cnt: 3, ovf: 1'b0};
    vecs[1] = '{n: 1, w: '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, cnt: 1, ovf: 1'b0};
    vecs[2] = '{n: 4, w: '{32'h00000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'hFFFFFFFF}, cnt: 4, ovf: 1'b0};
    vecs[3] = '{n: 4, w: '{32'hDEADBEEF, 32'hFFFFFFFF, 32'h01020304, 32'hFFFFFFFF}, cnt: 2, ovf: 1'b0};

    // Reset and idle.
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (20) @(negedge i_clk);
    chk("idle_outputs", {o_soft_reset, o_wea, o_busy, o_done, o_overflow, 5'(o_word_count), 4'(o_addr)},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0});

    // Table vectors, gaps alternating between back-to-back and spaced bytes.
    foreach (vecs[v]) begin
      tx_words.delete();
      for (int i = 0; i < vecs[v].n; i++) tx_words.push_back(vecs[v].w[i]);
      run_load(v % 2 == 0 ? 0 : 2);
      exp_a.delete(); exp_d.delete();
      for (int i = 0; i < vecs[v].cnt; i++) begin
        exp_a.push_back(4'(i)); exp_d.push_back(vecs[v].w[i]);
      end
      exp_ovf = vecs[v].ovf;
      check_result($sformatf("vec%0d", v));
    end

    // Overflow: 18 non-HALT words, the last two must be ignored.
    tx_words.delete();
    for (int i = 0; i < 18; i++) tx_words.push_back(32'h01010101 * (i + 1));
    run_load(0);
    model();
    chk("ovf_model", {63'd0, exp_ovf}, 64'd1);
    check_result("overflow");
    chk("ovf_addr15", 64'(o_addr), 64'd15);

    // Async reset mid-CLEAR.
    pulse_start();
    repeat (4) @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1 chk("rst_clear", {o_soft_reset, o_busy, o_done}, {1'b1, 1'b0, 1'b0});
    @(negedge i_clk) i_reset = 1'b1;

    // Async reset after two bytes of a word, then a fresh load.
    pulse_start();
    for (int c = 0; c < 100 && !(o_soft_reset && o_busy); c++) @(negedge i_clk);
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    #2 i_reset = 1'b0;
    #1 chk("rst_recv", {o_soft_reset, o_busy, 5'(o_word_count)}, {1'b1, 1'b0, 5'd0});
    @(negedge i_clk) i_reset = 1'b1;
    tx_words.delete();
    tx_words.push_back(32'h33445566);
    tx_words.push_back(HALT);
    run_load(1);
    model();
    check_result("after_rst");

    // Randomized loads against the model.
    for (int r = 0; r < 6; r++) begin
      int unsigned n = $urandom_range(1, 20);
      tx_words.delete();
      for (int i = 0; i < n; i++)
        tx_words.push_back(($urandom_range(0, 5) == 0) ? HALT : 32'($urandom));
      if (n < DEPTH) tx_words[n-1] = HALT;
      model();
      run_load(2);
      check_result($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
